// File: rtl/mem_access_unit_pkg.sv
// Shared processor definitions for the memory access unit: FSM states,
// operation codes and control-word bit positions.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'd0,
    MAU_ACCESS = 2'd1,
    MAU_DONE   = 2'd2
  } mau_state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mau_op_e;

  localparam int CTRL_FETCH_BIT = 0;
  localparam int CTRL_READ_BIT  = 1;
  localparam int CTRL_WRITE_BIT = 2;

  // Losing requests are not queued, so arbitration is a plain priority pick.
  function automatic mau_op_e arbitrate(input logic [2:0] ctrl);
    if (ctrl[CTRL_WRITE_BIT])     return OP_WRITE;
    else if (ctrl[CTRL_READ_BIT]) return OP_READ;
    else                          return OP_FETCH;
  endfunction

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating up-counter used for the access/stall performance statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_100,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: arbitrates fetch/read/write strobes onto one registered
// cache request port, waits for hit or timeout, and returns data with done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] memory_out,
  output logic              memory_write_en,
  output logic              cache_read,
  input  logic [DATA_W-1:0] memory_in,
  input  logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic              ir_load,
  output logic              mdr_load,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  mau_state_e        state, state_next;
  mau_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TMR_W-1:0]  timer;
  logic [2:0]        ctrl;
  logic              any_req;
  logic              in_access;
  logic              timer_expired;
  logic              finish;

  assign ctrl          = {write_req, read_req, fetch_req};
  assign any_req       = |ctrl;
  assign in_access     = (state == MAU_ACCESS);
  assign timer_expired = (timer == TMR_W'(TIMEOUT));
  assign finish        = in_access && (hit || timer_expired);

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) state <= MAU_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MAU_IDLE:   if (any_req) state_next = MAU_ACCESS;
      MAU_ACCESS: if (finish)  state_next = MAU_DONE;
      MAU_DONE:   if (!any_req) state_next = MAU_IDLE;
      default:    state_next = MAU_IDLE;
    endcase
  end

  // Operation and operands are latched at acceptance so requester changes
  // during the access cannot disturb the cache port.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      op_q     <= OP_FETCH;
      addr_q   <= '0;
      wdata_q  <= '0;
      timer    <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      ir_load  <= 1'b0;
      mdr_load <= 1'b0;
    end else begin
      ir_load  <= 1'b0;
      mdr_load <= 1'b0;
      if ((state == MAU_IDLE) && any_req) begin
        op_q    <= arbitrate(ctrl);
        addr_q  <= (ctrl[CTRL_WRITE_BIT] || ctrl[CTRL_READ_BIT]) ? mar_addr : pc_addr;
        wdata_q <= mdr_wdata;
        timer   <= '0;
        err     <= 1'b0;
      end else if (in_access) begin
        if (hit) begin
          if (op_q != OP_WRITE) begin
            rdata    <= memory_in;
            ir_load  <= (op_q == OP_FETCH);
            mdr_load <= (op_q == OP_READ);
          end
        end else if (timer_expired) begin
          err <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign address_out     = in_access ? addr_q : '0;
  assign memory_out      = in_access ? wdata_q : '0;
  assign cache_read      = in_access && (op_q != OP_WRITE);
  assign memory_write_en = in_access && (op_q == OP_WRITE);
  assign done            = (state == MAU_DONE);
  assign busy            = (state != MAU_IDLE);

  sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk_100 (clk_100),
    .rst     (rst),
    .inc     (finish),
    .q       (acc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_100 (clk_100),
    .rst     (rst),
    .inc     (in_access && !hit),
    .q       (stall_cnt)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected cache-port
// and completion records, a negedge monitor pops and compares them.
module tb_mem_access_unit;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic              clk_100 = 1'b0;
  logic              rst;
  logic              fetch_req, read_req, write_req;
  logic [ADDR_W-1:0] pc_addr, mar_addr;
  logic [DATA_W-1:0] mdr_wdata;
  logic [ADDR_W-1:0] address_out;
  logic [DATA_W-1:0] memory_out;
  logic              memory_write_en, cache_read;
  logic [DATA_W-1:0] memory_in;
  logic              hit;
  logic [DATA_W-1:0] rdata;
  logic              ir_load, mdr_load, done, err, busy;
  logic [CNT_W-1:0]  acc_cnt, stall_cnt;

  mem_access_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_100(clk_100), .rst(rst),
    .fetch_req(fetch_req), .read_req(read_req), .write_req(write_req),
    .pc_addr(pc_addr), .mar_addr(mar_addr), .mdr_wdata(mdr_wdata),
    .address_out(address_out), .memory_out(memory_out),
    .memory_write_en(memory_write_en), .cache_read(cache_read),
    .memory_in(memory_in), .hit(hit), .rdata(rdata),
    .ir_load(ir_load), .mdr_load(mdr_load), .done(done), .err(err),
    .busy(busy), .acc_cnt(acc_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              cr;
    logic              we;
  } acc_exp_t;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              ir;
    logic              mdr;
    logic              err;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  stall;
    int                lat;
  } done_exp_t;

  acc_exp_t  acc_q[$];
  done_exp_t done_q[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  int                acc_m   = 0;
  int                stall_m = 0;
  logic [DATA_W-1:0] rdata_m = '0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(v);
  endfunction

  always @(posedge clk_100) cycle <= cycle + 1;

  // Monitor: the first strobe cycle is matched against the cache-port queue,
  // the first done cycle against the completion queue.
  logic prev_acc  = 1'b0;
  logic prev_done = 1'b0;
  int   start_cyc = 0;

  always @(negedge clk_100) begin
    acc_exp_t  ae;
    done_exp_t de;
    logic      in_acc;
    if (rst) begin
      prev_acc  = 1'b0;
      prev_done = 1'b0;
    end else begin
      in_acc = cache_read | memory_write_en;
      if (in_acc && !prev_acc) begin
        start_cyc = cycle;
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_access: got addr 0x%0h with no expectation", address_out);
        end else begin
          ae = acc_q.pop_front();
          check_output("address_out", address_out, ae.addr);
          check_output("memory_out", memory_out, ae.wdata);
          check_output("cache_read", cache_read, ae.cr);
          check_output("memory_write_en", memory_write_en, ae.we);
          check_output("access_busy_done_err", {busy, done, err}, 3'b100);
        end
      end
      if (done && !prev_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done: got done=1 with no expectation");
        end else begin
          de = done_q.pop_front();
          check_output("rdata", rdata, de.rdata);
          check_output("ir_load", ir_load, de.ir);
          check_output("mdr_load", mdr_load, de.mdr);
          check_output("err", err, de.err);
          check_output("acc_cnt", acc_cnt, de.acc);
          check_output("stall_cnt", stall_cnt, de.stall);
          check_output("done_latency", cycle - start_cyc, de.lat);
          check_output("done_strobes_off", {cache_read, memory_write_en, address_out}, '0);
        end
      end else if (done && prev_done) begin
        check_output("load_pulse_width", {ir_load, mdr_load}, 2'b00);
      end
      prev_acc  = in_acc;
      prev_done = done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_port"}, {address_out, memory_out, cache_read, memory_write_en}, '0);
    check_output({tag, "_status"}, {done, err, busy, ir_load, mdr_load}, '0);
    check_output({tag, "_rdata"}, rdata, '0);
    check_output({tag, "_counters"}, {acc_cnt, stall_cnt}, '0);
  endtask

  // op: 0 fetch, 1 read, 2 write, 3 read+write together; hit_delay < 0 = never.
  task automatic apply_stimulus(input int op, input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] mar,
                                input logic [DATA_W-1:0] wd, input int hit_delay,
                                input logic [DATA_W-1:0] mem_val);
    acc_exp_t  ae;
    done_exp_t de;
    logic      is_write, is_fetch, tmo;
    int        n;
    is_write = (op >= 2);
    is_fetch = (op == 0);
    tmo      = (hit_delay < 0);
    ae.addr  = is_fetch ? pc : mar;
    ae.wdata = wd;
    ae.cr    = !is_write;
    ae.we    = is_write;
    acc_m   += 1;
    stall_m += tmo ? (TIMEOUT + 1) : hit_delay;
    if (!tmo && !is_write) rdata_m = mem_val;
    de.rdata = rdata_m;
    de.ir    = !tmo && is_fetch;
    de.mdr   = !tmo && (op == 1);
    de.err   = tmo;
    de.acc   = sat(acc_m);
    de.stall = sat(stall_m);
    de.lat   = tmo ? (TIMEOUT + 1) : (hit_delay + 1);
    acc_q.push_back(ae);
    done_q.push_back(de);

    pc_addr   = pc;
    mar_addr  = mar;
    mdr_wdata = wd;
    fetch_req = (op == 0);
    read_req  = (op == 1) || (op == 3);
    write_req = is_write;
    @(posedge clk_100); #1;
    memory_in = 16'hDEAD;
    if (!tmo) begin
      repeat (hit_delay) begin @(posedge clk_100); #1; end
      memory_in = mem_val;
      hit       = 1'b1;
      @(posedge clk_100); #1;
      hit       = 1'b0;
      memory_in = 16'hDEAD;
    end
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk_100); #1;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL done_wait: got done=0 after %0d cycles, required 1", n);
    end
    // Hold requests for an extra DONE cycle (with a stray hit) to check done holds.
    hit = 1'b1;
    @(posedge clk_100); #1;
    hit = 1'b0;
    check_output("done_held", done, 1'b1);
    fetch_req = 1'b0;
    read_req  = 1'b0;
    write_req = 1'b0;
    @(posedge clk_100); #1;
    check_output("back_to_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; read_req = 1'b0; write_req = 1'b0;
    pc_addr = '0; mar_addr = '0; mdr_wdata = '0; memory_in = '0; hit = 1'b0;
    repeat (3) @(posedge clk_100);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk_100); #1;

    $display("[TB] fetch with immediate hit");
    apply_stimulus(0, 16'h0001, 16'h0000, 16'h0000, 0, 16'hA5C3);

    $display("[TB] read and write together, write wins");
    apply_stimulus(3, 16'h0000, 16'h0040, 16'h1234, 0, 16'hFFFF);

    $display("[TB] read with hit delayed 3 cycles");
    apply_stimulus(1, 16'h0000, 16'h0100, 16'h0000, 3, 16'h5A5A);

    $display("[TB] read with no hit, timeout");
    apply_stimulus(1, 16'h0000, 16'h0200, 16'h0000, -1, 16'h0000);

    $display("[TB] read after timeout clears err");
    apply_stimulus(1, 16'h0000, 16'h0300, 16'h7777, 0, 16'h0F0F);

    $display("[TB] reset in the middle of an access");
    acc_q.push_back('{addr: 16'h0400, wdata: 16'h0000, cr: 1'b1, we: 1'b0});
    mar_addr = 16'h0400;
    mdr_wdata = 16'h0000;
    read_req = 1'b1;
    repeat (3) begin @(posedge clk_100); #1; end
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_access_reset");
    read_req = 1'b0;
    repeat (2) @(posedge clk_100);
    #1;
    rst = 1'b0;
    acc_m = 0; stall_m = 0; rdata_m = '0;
    @(posedge clk_100); #1;
    check_output("idle_after_reset", {busy, done}, 2'b00);
    apply_stimulus(0, 16'h0002, 16'h0000, 16'h0000, 0, 16'h1111);

    $display("[TB] 20 single-cycle fetches to saturate acc_cnt");
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 16'(i + 16), 16'h0000, 16'h0000, 0, 16'(16'h2000 + i));
    end
    check_output("acc_cnt_saturated", acc_cnt, 4'd15);

    @(posedge clk_100); #1;
    check_output("acc_queue_drained", acc_q.size(), 0);
    check_output("done_queue_drained", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access unit replacing the tristate MAR/MDR/PC/IR memory buses of the microprogrammed processor with a single registered request/acknowledge port to the cache. It takes the control unit's fetch, read and write strobes, arbitrates them, and holds the access until the cache reports `hit` or a timeout expires. It then returns fetched or read data with a `done` handshake. Saturating performance counters expose access and stall statistics.

## Interface
Parameters:
- `DATA_W`, 16, width of the data bus and of the IR/MDR data.
- `ADDR_W`, 16, width of the address bus.
- `TIMEOUT`, 15, maximum wait cycles for `hit` before the access is aborted (≥1).
- `CNT_W`, 16, width of the performance counters.

Ports:
- `clk_100`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `fetch_req`  in  1  instruction fetch request (control bit 0), level.
- `read_req`  in  1  data read request (control bit 1), level.
- `write_req`  in  1  data write request (control bit 2), level.
- `pc_addr`  in  ADDR_W  fetch address.
- `mar_addr`  in  ADDR_W  data address.
- `mdr_wdata`  in  DATA_W  write data.
- `address_out`  out  ADDR_W  registered address to the cache.
- `memory_out`  out  DATA_W  registered write data to the cache.
- `memory_write_en`  out  1  cache write strobe.
- `cache_read`  out  1  cache read strobe.
- `memory_in`  in  DATA_W  cache read data.
- `hit`  in  1  cache acknowledge.
- `rdata`  out  DATA_W  captured read/fetch data.
- `ir_load`  out  1  one-cycle pulse: `rdata` belongs to IR.
- `mdr_load`  out  1  one-cycle pulse: `rdata` belongs to MDR.
- `done`  out  1  access complete, held until all requests drop.
- `err`  out  1  last access timed out; valid while `done`.
- `busy`  out  1  state is not IDLE.
- `acc_cnt`  out  CNT_W  number of completed accesses, saturating.
- `stall_cnt`  out  CNT_W  number of ACCESS cycles without `hit`, saturating.

## Operation
- The FSM has three states:
  - IDLE: if any request is high, latch the operation and its address/data, clear the timer, go to ACCESS.
  - ACCESS: drive the cache strobes. On `hit`, go to DONE. When the timer reaches TIMEOUT, go to DONE with `err`=1.
  - DONE: hold `done`=1. When `fetch_req`, `read_req` and `write_req` are all 0, go to IDLE.
- Priority when several requests are high in IDLE: write > read > fetch. Requests that lose arbitration are not queued; the requester keeps them asserted.
- ACCESS outputs:
  - `address_out` = latched `mar_addr` for read/write, latched `pc_addr` for fetch.
  - `cache_read` = 1 for fetch or read.
  - `memory_write_en` = 1 for write.
  - `memory_out` = latched `mdr_wdata`.
- Outside ACCESS, `address_out`, `memory_out`, `cache_read` and `memory_write_en` are all 0. No output is ever high-Z.
- Capture on `hit` in ACCESS for fetch or read: `rdata` <= `memory_in`. The matching `ir_load` or `mdr_load` pulses for exactly the first DONE cycle. Writes and timeouts leave `rdata` unchanged and pulse no load.
- `hit` is ignored in IDLE and DONE.
- Request changes during ACCESS are ignored, because the operation and address are latched.
- Counters:
  - `acc_cnt` increments on every ACCESS→DONE transition, including timeouts.
  - `stall_cnt` increments on every ACCESS cycle with `hit`=0.
  - Both saturate at 2^CNT_W−1.
- Timer width is clog2(TIMEOUT+1).

## Timing
- Reset: state IDLE; every output is 0, including `rdata`, both counters and `err`. Reset mid-access aborts the access immediately, with no `done`.
- Latency: request sampled at edge N puts the FSM in ACCESS from cycle N+1. A `hit` sampled at edge M gives `done`/load/`rdata` valid in cycle M+1. The minimum request-to-done time is 2 cycles.
- Timeout: with no `hit`, `done`=1 and `err`=1 appear TIMEOUT+1 cycles after entering ACCESS.
- `err` clears on the next IDLE→ACCESS transition.
- Back-to-back accesses: the requester drops the request in a DONE cycle, the FSM spends one IDLE cycle, and a new request can then be accepted.

## Structure
- Shared processor package holds:
  - state encoding constants `MAU_IDLE`, `MAU_ACCESS`, `MAU_DONE`;
  - operation codes `OP_FETCH`, `OP_READ`, `OP_WRITE`;
  - the control-word bit indices 0/1/2 for fetch/read/write.
- One sub-module, `sat_counter` (params `W`; ports `clk_100`, `rst`, `inc`, `q`), instantiated twice for `acc_cnt` and `stall_cnt`.

## Test plan
- Fetch, `pc_addr`=0x0001, `hit` on first ACCESS cycle, `memory_in`=0xA5C3 → `cache_read`=1 with `address_out`=0x0001 for one cycle; then `done`=1, `ir_load` pulse, `rdata`=0xA5C3, `acc_cnt`=1, `stall_cnt`=0.
- Read and write requested together, `mar_addr`=0x0040, `mdr_wdata`=0x1234 → write wins: `memory_write_en`=1, `memory_out`=0x1234, `cache_read`=0, no load pulse.
- Read with `hit` delayed 3 cycles → `done` 4 cycles after ACCESS entry, `mdr_load` pulse, `stall_cnt`=3.
- Read, `hit` never asserted, TIMEOUT=15 → `done`=1 and `err`=1 at ACCESS+16, `rdata` unchanged; next access clears `err`.
- `rst` asserted in the middle of ACCESS → all outputs 0 in the same cycle, state IDLE, no `done`; a new fetch after release completes normally.
- With CNT_W=4, 20 one-cycle accesses → `acc_cnt` saturates at 15.
